// File: rtl/glm_pkg.sv
// Shared constants and types for the GLM panel frame buffer.
package glm_pkg;

  // Default panel geometry
  localparam int GLM_COLS_DEF      = 32;
  localparam int GLM_SCAN_ROWS_DEF = 8;

  // rd_data layout: {R1,G1,B1,R2,G2,B2}, top half pixel in the upper field
  localparam int RD_W       = 6;
  localparam int RD_TOP_MSB = 5;
  localparam int RD_TOP_LSB = 3;
  localparam int RD_BOT_MSB = 2;
  localparam int RD_BOT_LSB = 0;

  // Frame-swap controller states
  typedef enum logic [0:0] {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

endpackage

// File: rtl/glm_fb_ram.sv
// Half-panel pixel memory: one write port, one registered read port.
// A same-address read and write in one cycle returns the previous contents.
module glm_fb_ram
  import glm_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [2**AW];

  // Pixel storage update; contents are not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read, held while re is low
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= {DW{1'b0}};
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/glm_framebuf.sv
// GLM LED-panel frame buffer: host writes pixels into the back bank, the scan
// driver reads top/bottom half pixel pairs from the front bank.
// Build option GLM_FB_DOUBLE_EN: defined -> double-buffered with a frame-swap
// controller; undefined -> one shared bank, swap_req is acknowledged next cycle.
module glm_framebuf
  import glm_pkg::*;
#(
  parameter int COLS      = GLM_COLS_DEF,
  parameter int SCAN_ROWS = GLM_SCAN_ROWS_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [$clog2(COLS)-1:0]        wr_x,
  input  logic [$clog2(2*SCAN_ROWS)-1:0] wr_y,
  input  logic [2:0]                     wr_rgb,
  input  logic                           clr_req,
  output logic                           busy,
  input  logic                           swap_req,
  output logic                           swap_ack,
  input  logic                           rd_en,
  input  logic [$clog2(SCAN_ROWS)-1:0]   rd_row,
  input  logic [$clog2(COLS)-1:0]        rd_col,
  input  logic                           frame_end,
  output logic [RD_W-1:0]                rd_data,
  output logic                           rd_valid
);

  localparam int XW = $clog2(COLS);
  localparam int RW = $clog2(SCAN_ROWS);
  localparam int YW = RW + 1;
  localparam int AW = RW + XW;
`ifdef GLM_FB_DOUBLE_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  logic          busy_r;
  logic [AW-1:0] clr_cnt_r;
  logic          swap_ack_r;
  logic          rd_valid_r;
  logic          swap_go_s;
  logic          back_bank_s;
  logic          host_wr_s;
  logic [AW-1:0] ram_waddr_s;
  logic [2:0]    ram_wdata_s;
  logic [1:0]    half_we_s;   // [0] top half, [1] bottom half
  logic [2:0]    ram_rdata_s [NBANK][2];

  // Write-port steering: the clear sequencer owns both halves while busy
  always_comb begin
    host_wr_s   = wr_en & ~busy_r;
    ram_waddr_s = {wr_y[RW-1:0], wr_x};
    ram_wdata_s = wr_rgb;
    half_we_s   = 2'b00;
    if (busy_r) begin
      ram_waddr_s = clr_cnt_r;
      ram_wdata_s = 3'b000;
      half_we_s   = 2'b11;
    end else begin
      half_we_s = {wr_y[YW-1] & host_wr_s, ~wr_y[YW-1] & host_wr_s};
    end
  end

  // Clear sequencer: one address per cycle across the whole back bank
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r    <= 1'b0;
      clr_cnt_r <= {AW{1'b0}};
    end else if (busy_r) begin
      clr_cnt_r <= clr_cnt_r + AW'(1'b1);
      if (clr_cnt_r == {AW{1'b1}}) begin
        busy_r <= 1'b0;
      end
    end else if (clr_req) begin
      busy_r    <= 1'b1;
      clr_cnt_r <= {AW{1'b0}};
    end
  end

`ifdef GLM_FB_DOUBLE_EN
  swap_state_e state_r;
  swap_state_e state_nx_s;
  logic        front_r;
  logic        rd_bank_r;

  // Swap controller state and front-bank select
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SWAP_IDLE;
      front_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      front_r <= front_r ^ swap_go_s;
    end
  end

  // Swap controller next state: swap lands on a frame_end cycle
  always_comb begin
    state_nx_s = state_r;
    swap_go_s  = 1'b0;
    case (state_r)
      SWAP_IDLE: begin
        if (swap_req && !busy_r) begin
          if (frame_end) begin
            swap_go_s = 1'b1;
          end else begin
            state_nx_s = SWAP_PENDING;
          end
        end else begin
          state_nx_s = SWAP_IDLE;
        end
      end
      SWAP_PENDING: begin
        if (frame_end) begin
          swap_go_s  = 1'b1;
          state_nx_s = SWAP_IDLE;
        end else begin
          state_nx_s = SWAP_PENDING;
        end
      end
      default: begin
        state_nx_s = SWAP_IDLE;
      end
    endcase
  end

  assign back_bank_s = ~front_r;

  // Remember which bank a read targeted so its data stays selected until the next read
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank_r <= 1'b0;
    end else if (rd_en) begin
      rd_bank_r <= front_r;
    end
  end

  // Pack the two half-panel pixels of the selected bank
  always_comb begin
    rd_data = {RD_W{1'b0}};
    rd_data[RD_TOP_MSB:RD_TOP_LSB] = ram_rdata_s[rd_bank_r][0];
    rd_data[RD_BOT_MSB:RD_BOT_LSB] = ram_rdata_s[rd_bank_r][1];
  end
`else
  logic unused_frame_end_s;

  // Single bank: a swap request is acknowledged without waiting for frame_end
  always_comb begin
    swap_go_s          = swap_req & ~busy_r;
    back_bank_s        = 1'b0;
    unused_frame_end_s = frame_end;
  end

  // Pack the two half-panel pixels of the shared bank
  always_comb begin
    rd_data = {RD_W{1'b0}};
    rd_data[RD_TOP_MSB:RD_TOP_LSB] = ram_rdata_s[0][0];
    rd_data[RD_BOT_MSB:RD_BOT_LSB] = ram_rdata_s[0][1];
  end
`endif

  // Registered swap acknowledge and read-valid strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      swap_ack_r <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      swap_ack_r <= swap_go_s;
      rd_valid_r <= rd_en;
    end
  end

  assign busy     = busy_r;
  assign swap_ack = swap_ack_r;
  assign rd_valid = rd_valid_r;

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    for (genvar h = 0; h < 2; h++) begin : g_half
      glm_fb_ram #(.AW(AW), .DW(3)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (half_we_s[h] & (back_bank_s == 1'(b))),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .re    (rd_en),
        .raddr ({rd_row, rd_col}),
        .rdata (ram_rdata_s[b][h])
      );
    end
  end

endmodule

// File: tb/tb_glm_framebuf.sv
// Self-checking bench for glm_framebuf (default parameters). The reference
// model keeps whole panel images per bank and applies the frame-buffer rules
// once per clock; honours GLM_FB_DOUBLE_EN the same way the design does.
module tb_glm_framebuf;

  localparam int C = 32;
  localparam int S = 8;
  localparam int N = S * C;
`ifdef GLM_FB_DOUBLE_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, wr_en, clr_req, busy, swap_req, swap_ack, rd_en, frame_end, rd_valid;
  logic [4:0] wr_x, rd_col;
  logic [3:0] wr_y;
  logic [2:0] wr_rgb, rd_row;
  logic [5:0] rd_data;

  int total = 0;
  int bad   = 0;

  // Reference model state: image[bank][y][x], y covers the full panel height
  logic [2:0] m_mem [2][16][32];
  int         m_front;
  bit         m_pend;
  int         m_busy;
  bit         m_ack;
  logic [5:0] m_rd;
  bit         m_valid;

  glm_framebuf dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
    .clr_req(clr_req), .busy(busy), .swap_req(swap_req), .swap_ack(swap_ack),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .frame_end(frame_end),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  // Apply one clock of the frame-buffer rules to the model, then advance the DUT
  task automatic tick();
    int back;
    bit busy_now;
    bit nack;
    if (rst) begin
      m_front = 0; m_pend = 1'b0; m_busy = 0; m_ack = 1'b0; m_rd = 6'd0; m_valid = 1'b0;
    end else begin
      busy_now = (m_busy > 0);
      back     = DBL ? 1 - m_front : 0;
      if (rd_en) begin
        m_rd    = {m_mem[m_front][rd_row][rd_col], m_mem[m_front][int'(rd_row) + S][rd_col]};
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (busy_now) begin
        m_busy--;
      end else begin
        if (wr_en) m_mem[back][wr_y][wr_x] = wr_rgb;
        if (clr_req) begin
          for (int y = 0; y < 16; y++)
            for (int x = 0; x < 32; x++) m_mem[back][y][x] = 3'd0;
          m_busy = N;
        end
      end
      nack = 1'b0;
      if (DBL) begin
        if (!m_pend) begin
          if (swap_req && !busy_now) begin
            if (frame_end) begin m_front = 1 - m_front; nack = 1'b1; end
            else m_pend = 1'b1;
          end
        end else if (frame_end) begin
          m_front = 1 - m_front; m_pend = 1'b0; nack = 1'b1;
        end
      end else begin
        nack = swap_req && !busy_now;
      end
      m_ack = nack;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_x = 5'd0; wr_y = 4'd0; wr_rgb = 3'd0; clr_req = 1'b0;
    swap_req = 1'b0; rd_en = 1'b0; rd_row = 3'd0; rd_col = 5'd0; frame_end = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    rd_en = 1'b1; swap_req = 1'b1; clr_req = 1'b1; frame_end = 1'b1;
    repeat (3) tick();
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (swap_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%0b exp=0", swap_ack); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", rd_valid); end
    total++; if (rd_data !== 6'd0)  begin bad++; $display("FAIL reset_data got=%0h exp=0", rd_data); end
    rst = 1'b0; idle_inputs();
    tick();
    total++; if (busy !== 1'b0 || swap_ack !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle got=%0b%0b exp=00", busy, swap_ack);
    end
  endtask

  // Clear the back bank while hammering ignored writes/requests; busy must last N cycles
  task automatic do_clear(input string tag);
    int nb;
    nb = 0;
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (busy !== 1'b1) break;
      nb++;
      total++; if (swap_ack !== m_ack) begin
        bad++; $display("FAIL %s ack_while_busy got=%0b exp=%0b", tag, swap_ack, m_ack);
      end
      wr_en = 1'b1; wr_x = 5'($urandom); wr_y = 4'($urandom); wr_rgb = 3'($urandom);
      clr_req = 1'($urandom); swap_req = 1'($urandom);
      tick();
    end
    wr_en = 1'b0; clr_req = 1'b0; swap_req = 1'b0;
    total++; if (nb != N) begin bad++; $display("FAIL %s busy_cycles got=%0d exp=%0d", tag, nb, N); end
  endtask

  task automatic test_clear();
    do_clear("clear_a");
    swap_req = 1'b1; frame_end = 1'b1; tick(); swap_req = 1'b0; frame_end = 1'b0;
    total++; if (swap_ack !== 1'b1) begin bad++; $display("FAIL clear_swap_ack got=%0b exp=1", swap_ack); end
    tick();
    do_clear("clear_b");
    for (int r = 0; r < S; r++) begin
      for (int c = 0; c < C; c++) begin
        rd_en = 1'b1; rd_row = r[2:0]; rd_col = c[4:0]; tick();
        total++; if (rd_data !== 6'd0 || rd_valid !== 1'b1) begin
          bad++; $display("FAIL clear_read r=%0d c=%0d got=%0h/%0b exp=0/1", r, c, rd_data, rd_valid);
        end
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_directed();
    logic [5:0] exp_pre;
    wr_en = 1'b1; wr_x = 5'd3; wr_y = 4'd2; wr_rgb = 3'b100; tick(); wr_en = 1'b0;
    rd_en = 1'b1; rd_row = 3'd2; rd_col = 5'd3; tick(); rd_en = 1'b0;
`ifdef GLM_FB_DOUBLE_EN
    exp_pre = 6'b000000;
`else
    exp_pre = 6'b100000;
`endif
    total++; if (rd_data !== exp_pre) begin bad++; $display("FAIL pre_swap_read got=%0h exp=%0h", rd_data, exp_pre); end
    total++; if (rd_data !== m_rd) begin bad++; $display("FAIL pre_swap_model got=%0h exp=%0h", rd_data, m_rd); end
    swap_req = 1'b1; frame_end = 1'b1; tick(); swap_req = 1'b0; frame_end = 1'b0;
    total++; if (swap_ack !== 1'b1) begin bad++; $display("FAIL swap_same_cycle_ack got=%0b exp=1", swap_ack); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    total++; if (rd_data !== 6'b100000 || rd_valid !== 1'b1) begin
      bad++; $display("FAIL post_swap_read got=%0h/%0b exp=20/1", rd_data, rd_valid);
    end
    rd_row = 3'd5; rd_col = 5'd9; tick();
    total++; if (rd_data !== 6'b100000 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL read_hold got=%0h/%0b exp=20/0", rd_data, rd_valid);
    end
    wr_en = 1'b1; wr_x = 5'd3; wr_y = 4'd10; wr_rgb = 3'b001; tick(); wr_en = 1'b0;
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    total++; if (swap_ack !== m_ack) begin bad++; $display("FAIL swap_req_ack got=%0b exp=%0b", swap_ack, m_ack); end
    for (int i = 0; i < 19; i++) begin
      tick();
      total++; if (swap_ack !== m_ack) begin bad++; $display("FAIL wait_ack i=%0d got=%0b exp=%0b", i, swap_ack, m_ack); end
    end
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    total++; if (swap_ack !== m_ack) begin bad++; $display("FAIL frame_end_ack got=%0b exp=%0b", swap_ack, m_ack); end
`ifdef GLM_FB_DOUBLE_EN
    total++; if (swap_ack !== 1'b1) begin bad++; $display("FAIL frame_end_ack_dbl got=%0b exp=1", swap_ack); end
`endif
    tick();
    total++; if (swap_ack !== 1'b0) begin bad++; $display("FAIL ack_one_cycle got=%0b exp=0", swap_ack); end
    rd_en = 1'b1; rd_row = 3'd2; rd_col = 5'd3; tick(); rd_en = 1'b0;
    total++; if (rd_data[2:0] !== 3'b001) begin bad++; $display("FAIL bottom_read got=%0h exp=1", rd_data[2:0]); end
    total++; if (rd_data !== m_rd) begin bad++; $display("FAIL bottom_model got=%0h exp=%0h", rd_data, m_rd); end
  endtask

  task automatic test_swap_reset();
    logic [5:0] exp_rd;
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    total++; if (swap_ack !== 1'b0) begin bad++; $display("FAIL rst_pending_ack got=%0b exp=0", swap_ack); end
    tick();
    total++; if (swap_ack !== 1'b0) begin bad++; $display("FAIL rst_pending_ack2 got=%0b exp=0", swap_ack); end
    rd_en = 1'b1; rd_row = 3'd2; rd_col = 5'd3; tick(); rd_en = 1'b0;
`ifdef GLM_FB_DOUBLE_EN
    exp_rd = 6'b100000;
`else
    exp_rd = 6'b100001;
`endif
    total++; if (rd_data !== exp_rd) begin bad++; $display("FAIL front_after_rst got=%0h exp=%0h", rd_data, exp_rd); end
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    repeat (5) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_clear_busy got=%0b exp=1", busy); end
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_abort got=%0b exp=0", busy); end
    repeat (3) tick();
    total++; if (busy !== 1'b0 || swap_ack !== 1'b0) begin
      bad++; $display("FAIL after_abort got=%0b%0b exp=00", busy, swap_ack);
    end
    do_clear("clear_after_abort");
  endtask

  // Same-address read and write every cycle: read returns pre-write data
  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_x = 5'($urandom); wr_y = 4'($urandom); wr_rgb = 3'($urandom);
      rd_en = 1'b1; rd_row = wr_y[2:0]; rd_col = wr_x;
      tick();
      total++; if (rd_data !== m_rd || rd_valid !== 1'b1) begin
        bad++; $display("FAIL b2b_rw i=%0d got=%0h exp=%0h", i, rd_data, m_rd);
      end
      wr_en = 1'b0;
      tick();
      total++; if (rd_data !== m_rd) begin bad++; $display("FAIL b2b_reread i=%0d got=%0h exp=%0h", i, rd_data, m_rd); end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      wr_en = 1'($urandom); wr_x = 5'($urandom); wr_y = 4'($urandom); wr_rgb = 3'($urandom);
      rd_en = 1'($urandom); rd_row = 3'($urandom); rd_col = 5'($urandom);
      swap_req  = ($urandom_range(0, 7) == 0);
      frame_end = ($urandom_range(0, 9) == 0);
      clr_req   = ($urandom_range(0, 199) == 0);
      if (clr_req) frame_end = 1'b0;
      if (m_busy > 0) begin
        frame_end = 1'b0;
        if (!DBL) rd_en = 1'b0;
      end
      tick();
      total++; if (rd_data !== m_rd)     begin bad++; $display("FAIL rnd_data i=%0d got=%0h exp=%0h", i, rd_data, m_rd); end
      total++; if (rd_valid !== m_valid) begin bad++; $display("FAIL rnd_valid i=%0d got=%0b exp=%0b", i, rd_valid, m_valid); end
      total++; if (busy !== (m_busy > 0)) begin bad++; $display("FAIL rnd_busy i=%0d got=%0b exp=%0b", i, busy, m_busy > 0); end
      total++; if (swap_ack !== m_ack)   begin bad++; $display("FAIL rnd_ack i=%0d got=%0b exp=%0b", i, swap_ack, m_ack); end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_front = 0; m_pend = 1'b0; m_busy = 0; m_ack = 1'b0; m_rd = 6'd0; m_valid = 1'b0;
    test_reset();
    test_clear();
    test_directed();
    test_swap_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/glm_framebuf.md
GLM_FRAMEBUF -- requirements
Module: glm_framebuf

Interface
REQ-001 SHALL have parameter COLS, default 32, panel columns (power of two).
REQ-002 SHALL have parameter SCAN_ROWS, default 8, scan rows per half-panel (power of two); panel height = 2*SCAN_ROWS.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports wr_en input 1, wr_x input log2(COLS), wr_y input log2(2*SCAN_ROWS), wr_rgb input 3 ({R,G,B}): host pixel write.
REQ-006 SHALL have ports clr_req input 1, busy output 1: back-buffer clear request and clear-in-progress flag.
REQ-007 SHALL have ports swap_req input 1 and swap_ack output 1: frame-swap request and one-cycle completion pulse.
REQ-008 SHALL have ports rd_en input 1, rd_row input log2(SCAN_ROWS), rd_col input log2(COLS), frame_end input 1: scan-driver read side.
REQ-009 SHALL have ports rd_data output 6 ({R1,G1,B1,R2,G2,B2}) and rd_valid output 1.

Function
REQ-010 SHALL store two half-panel memories (top: y < SCAN_ROWS, bottom: y >= SCAN_ROWS), each SCAN_ROWS*COLS x 3 bits per bank.
REQ-011 SHALL write wr_rgb to the back bank at (wr_x, wr_y mod SCAN_ROWS) of the half selected by wr_y MSB on the cycle wr_en is high.
REQ-012 SHALL return on rd_data, exactly one cycle after rd_en, front-bank top pixel in bits [5:3] and bottom pixel in bits [2:0] at (rd_row, rd_col); rd_valid SHALL pulse high that cycle.
REQ-013 SHALL hold rd_data unchanged when rd_en is low.
REQ-014 SHALL run a swap FSM IDLE -> PENDING (swap_req) -> IDLE (frame_end), toggling front/back select on the frame_end cycle and asserting swap_ack for one cycle on the following cycle.
REQ-015 SHALL, if swap_req and frame_end are high in the same IDLE cycle, swap on that cycle.
REQ-016 SHALL ignore swap_req while PENDING or while busy.
REQ-017 SHALL, on clr_req while not busy, write 0 to every back-bank location of both halves, one address per cycle, busy high for exactly SCAN_ROWS*COLS cycles starting the next cycle.
REQ-018 SHALL ignore wr_en and clr_req while busy; reads SHALL proceed unaffected.
REQ-019 SHALL give reads priority-free read-before-write semantics: a same-address read and write in one cycle returns the old value.

Reset
REQ-020 SHALL, while rst is high, set FSM to IDLE, front select to bank 0, busy=0, swap_ack=0, rd_valid=0, rd_data=0, abort any clear; memory contents undefined.
REQ-021 SHALL take reset mid-clear or mid-pending without any subsequent swap_ack.

Configuration
REQ-022 SHALL support macro GLM_FB_DOUBLE_EN: defined -> two banks as above; undefined -> single bank, writes and reads share it, swap_req produces swap_ack the next cycle with no frame_end wait.

Structure
REQ-023 SHALL place rd_data bit-field positions, FSM state encoding, and default COLS/SCAN_ROWS constants in shared package glm_pkg.
REQ-024 SHALL implement each memory as sub-module glm_fb_ram (one write, one registered read port), instantiated per half per bank.

Verification
REQ-025 Reset, write (x=3,y=2,rgb=3'b100), swap_req+frame_end, rd_en row=2 col=3 -> next cycle rd_data=6'b100000, rd_valid=1.
REQ-026 Write (x=3,y=10,rgb=3'b001), swap_req, frame_end 20 cycles later -> swap_ack exactly 1 cycle after frame_end; read row=2 col=3 -> rd_data[2:0]=3'b001.
REQ-027 Before swap, read after back-bank write -> rd_data reflects old front data (0 after clear).
REQ-028 clr_req at cycle 0 -> busy high cycles 1..256 (default params); wr_en during busy -> no write; after swap all reads 6'b000000.
REQ-029 Undefined GLM_FB_DOUBLE_EN: write then read same cycle returns old value, next read returns new; swap_req -> swap_ack next cycle.
REQ-030 swap_req then rst during PENDING, then frame_end -> no swap_ack, front remains bank 0.
